// File: rtl/rx_word_assembler.sv
// Reassembles UART receive bytes MSB-first into N_BIT words, dropping partials on inter-byte timeout.
// Word valid 1 cycle after last byte; a full holding register not accepted in that cycle drops the new word (overrun).
module rx_word_assembler #(
  parameter int N_BIT          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sync_clear,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic [N_BIT-1:0] o_word_out,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_frame_error,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int BYTECOUNT = (N_BIT + 7) / 8;
  localparam int R         = N_BIT % 8;
  localparam int LAST_W    = (R == 0) ? 8 : R;
  localparam int SHR       = 8 - LAST_W;
  localparam int IW        = (BYTECOUNT > 1) ? $clog2(BYTECOUNT) : 1;
  localparam int CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTECOUNT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [N_BIT-1:0] r_shift, w_shift_nxt;
  logic [N_BIT-1:0] r_word;
  logic             r_word_vld, r_frame_err, r_overrun;
  logic             w_complete, w_timeout;
  logic [N_BIT-1:0] w_base, w_word;
  logic [N_BIT+7:0] w_acc8;

  // A new word always starts from zero, so the first byte never inherits stale bits.
  assign w_base = (r_state == S_COLLECT) ? r_shift : '0;
  assign w_acc8 = {w_base, i_rx_data};
  assign w_word = N_BIT'(w_acc8 >> SHR);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    if (i_sync_clear) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (i_rx_valid) begin
            if (BYTECOUNT == 1) begin
              w_complete  = 1'b1;
              w_shift_nxt = '0;
            end else begin
              w_shift_nxt = N_BIT'(w_acc8);
              w_idx_nxt   = IW'(1);
              w_state_nxt = S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (i_rx_valid) begin
            w_cnt_nxt = '0;
            if (r_idx == LAST_IDX) begin
              w_complete  = 1'b1;
              w_idx_nxt   = '0;
              w_shift_nxt = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_shift_nxt = N_BIT'(w_acc8);
              w_idx_nxt   = r_idx + IW'(1);
            end
          end else if (r_cnt == CNT_MAX) begin
            w_timeout   = 1'b1;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Holding register: a same-cycle accept frees the slot for the completing word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word      <= '0;
      r_word_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;
      r_overrun   <= 1'b0;
      if (w_complete) begin
        if (!r_word_vld || i_word_ready) begin
          r_word     <= w_word;
          r_word_vld <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_word_vld && i_word_ready) begin
        r_word_vld <= 1'b0;
      end
    end
  end

  assign o_word_out    = r_word;
  assign o_word_valid  = r_word_vld;
  assign o_frame_error = r_frame_err;
  assign o_overrun     = r_overrun;
  assign o_busy        = (r_state == S_COLLECT);

endmodule

// File: tb/tb_rx_word_assembler.sv
// Bench for rx_word_assembler: directed scenarios plus random traffic against a byte-queue reference model.
module tb_rx_word_assembler;

  localparam int TB_N  = 12;
  localparam int TB_TO = 10;
  localparam int TB_BC = (TB_N + 7) / 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            sync_clear;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            word_ready;
  logic [TB_N-1:0] word_out;
  logic            word_valid;
  logic            frame_error;
  logic            overrun;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]      m_bytes[$];
  int              m_gap;
  logic            m_valid;
  logic [TB_N-1:0] m_word;
  logic            e_fe, e_ov;

  rx_word_assembler #(.N_BIT(TB_N), .TIMEOUT_CYCLES(TB_TO)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_sync_clear (sync_clear),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_word_out   (word_out),
    .o_word_valid (word_valid),
    .i_word_ready (word_ready),
    .o_frame_error(frame_error),
    .o_overrun    (overrun),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_gap   = 0;
    m_valid = 1'b0;
    m_word  = '0;
    e_fe    = 1'b0;
    e_ov    = 1'b0;
  endtask

  // Word = bytes concatenated MSB-first, then the unused low bits of the last byte dropped.
  task automatic model_step();
    logic            complete;
    logic [TB_N-1:0] new_word;
    longint          acc;
    complete = 1'b0;
    new_word = '0;
    e_fe     = 1'b0;
    e_ov     = 1'b0;
    if (sync_clear) begin
      m_bytes.delete();
      m_gap = 0;
    end else if (rx_valid) begin
      m_bytes.push_back(rx_data);
      m_gap = 0;
      if (m_bytes.size() == TB_BC) begin
        acc = 0;
        foreach (m_bytes[i]) acc = (acc << 8) | longint'(m_bytes[i]);
        new_word = TB_N'(acc >> (8 * TB_BC - TB_N));
        complete = 1'b1;
        m_bytes.delete();
      end
    end else if (m_bytes.size() > 0) begin
      m_gap++;
      if (m_gap == TB_TO) begin
        m_bytes.delete();
        m_gap = 0;
        e_fe  = 1'b1;
      end
    end
    if (complete) begin
      if (!m_valid || word_ready) begin
        m_word  = new_word;
        m_valid = 1'b1;
      end else begin
        e_ov = 1'b1;
      end
    end else if (m_valid && word_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ph);
    check_eq({ph, ".word_valid"},  32'(word_valid),  32'(m_valid));
    check_eq({ph, ".word_out"},    32'(word_out),    32'(m_word));
    check_eq({ph, ".frame_error"}, 32'(frame_error), 32'(e_fe));
    check_eq({ph, ".overrun"},     32'(overrun),     32'(e_ov));
    check_eq({ph, ".busy"},        32'(busy),        32'(m_bytes.size() > 0));
  endtask

  task automatic cycle(input logic rv, input logic [7:0] rd, input logic rdy, input logic sc);
    rx_valid   = rv;
    rx_data    = rd;
    word_ready = rdy;
    sync_clear = sc;
    @(posedge clk);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset(input int ncyc);
    rx_valid   = 1'b0;
    sync_clear = 1'b0;
    reset_n    = 1'b0;
    model_reset();
    #1;
    check_outputs("rst");
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_outputs("rst");
    end
    reset_n = 1'b1;
  endtask

  initial begin
    int fe_at, fe_cnt, ov_cnt;
    int p_valid, p_ready;
    reset_n    = 1'b0;
    sync_clear = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    word_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // Two-byte word; low nibble of the second byte is ignored.
    cycle(1'b1, 8'hAB, 1'b1, 1'b0);
    cycle(1'b1, 8'hC5, 1'b1, 1'b0);
    check_eq("abc.word", 32'(word_out), 32'h0ABC);
    check_eq("abc.valid", 32'(word_valid), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("abc.valid_drop", 32'(word_valid), 32'd0);

    // Inter-byte timeout discards the partial byte.
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    fe_at = 0; fe_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (frame_error) begin fe_at = k; fe_cnt++; end
    end
    check_eq("to.pulse_at", 32'(fe_at), 32'd10);
    check_eq("to.pulse_cnt", 32'(fe_cnt), 32'd1);
    cycle(1'b1, 8'h34, 1'b1, 1'b0);
    cycle(1'b1, 8'h56, 1'b1, 1'b0);
    check_eq("to.next_word", 32'(word_out), 32'h345);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Overrun: holding register full and not accepted.
    ov_cnt = 0;
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    if (overrun) ov_cnt++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    if (overrun) ov_cnt++;
    check_eq("ov.kept_word", 32'(word_out), 32'h111);
    check_eq("ov.pulse_cnt", 32'(ov_cnt), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("ov.valid_drop", 32'(word_valid), 32'd0);

    // Accept and reload in the same cycle.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    check_eq("reload.word", 32'(word_out), 32'hBBB);
    check_eq("reload.valid", 32'(word_valid), 32'd1);
    check_eq("reload.overrun", 32'(overrun), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Byte arriving in the last cycle before timeout is accepted.
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    fe_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (frame_error) fe_cnt++;
    end
    cycle(1'b1, 8'h34, 1'b1, 1'b0);
    check_eq("edge.word", 32'(word_out), 32'h123);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    if (frame_error) fe_cnt++;
    check_eq("edge.no_fe", 32'(fe_cnt), 32'd0);

    // Sync clear aborts the partial and ignores a same-cycle byte.
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    check_eq("sclr.busy", 32'(busy), 32'd0);
    cycle(1'b1, 8'hAB, 1'b1, 1'b0);
    cycle(1'b1, 8'hCD, 1'b1, 1'b0);
    check_eq("sclr.word", 32'(word_out), 32'hABC);

    // Reset mid-word.
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    do_reset(2);
    check_eq("rstmid.word", 32'(word_out), 32'h0);
    cycle(1'b1, 8'h03, 1'b1, 1'b0);
    cycle(1'b1, 8'h04, 1'b1, 1'b0);
    check_eq("rstmid.new_word", 32'(word_out), 32'h030);
    check_eq("rstmid.busy", 32'(busy), 32'd0);

    // Random traffic in segments of differing byte density and consumer readiness.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 2))
        0: p_valid = 3;
        1: p_valid = 25;
        default: p_valid = 70;
      endcase
      case ($urandom_range(0, 2))
        0: p_ready = 0;
        1: p_ready = 50;
        default: p_ready = 100;
      endcase
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 999) < 3) begin
          do_reset($urandom_range(1, 2));
        end else begin
          cycle(1'($urandom_range(0, 99) < p_valid), 8'($urandom),
                1'($urandom_range(0, 99) < p_ready), 1'($urandom_range(0, 99) < 2));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
